// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types only). Backpressure: n/a.
// The queue entry carries the fetched word together with the address it was fetched from.
package fetch_pkg;

    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OPC_HLT = 4'hF;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 4] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush wins over push/pop.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push is dropped when full, pop is ignored when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 din,
    output fetch_entry_t                 head,
    output logic [$clog2(QDEPTH+1)-1:0]  count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    fetch_entry_t     mem [QDEPTH];
    fetch_entry_t     hold_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(QDEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // When the queue drains, the head keeps showing the last entry it presented.
    assign head = empty ? hold_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (!empty) begin
                hold_q <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the IM on the negedge and queues words for decode.
// Latency: word at PC reaches id_instr one cycle after im_rd_en; redirect shows 2 cycles after br_taken.
// Backpressure: id_ready only drains the queue; fetch stops when full. Optional FETCH_PERF_EN adds perf counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  im_addr,
    output logic               im_rd_en,
    input  logic [INSTR_W-1:0] im_instr,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt
`endif
);

    logic [ADDR_W-1:0]            pc;
    logic                         halted_q;
    logic                         fetch_go;
    logic                         q_pop;
    logic                         q_full;
    logic                         q_empty;
    logic [$clog2(QDEPTH+1)-1:0]  q_count;
    fetch_entry_t                 q_din;
    fetch_entry_t                 q_head;

    // Fetch never looks at id_ready; a full queue is the only throttle.
    assign fetch_go = !rst && !halted_q && !br_taken && !q_full;
    assign q_pop    = id_ready && !q_empty && !br_taken;
    assign q_din    = '{instr: im_instr, pc: pc};

    assign im_addr  = pc;
    assign im_rd_en = fetch_go;
    assign id_valid = !rst && (q_count != '0);
    assign id_instr = q_head.instr;
    assign id_pc    = q_head.pc;
    assign halted   = halted_q;

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch_go),
        .pop   (q_pop),
        .flush (br_taken),
        .din   (q_din),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            halted_q <= 1'b0;
        end else if (br_taken) begin
            pc       <= br_target;
            halted_q <= 1'b0;
        end else if (fetch_go) begin
            pc <= pc + 1'b1;
            if (is_hlt(im_instr)) begin
                halted_q <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_go && perf_fetch_cnt != 16'hFFFF) begin
                perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            end
            if (!halted_q && !br_taken && q_full && perf_stall_cnt != 16'hFFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for halt/wrap/reset,
// then random traffic against a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int QD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, br_taken, id_ready, im_rd_en, id_valid, halted;
    logic [ADDR_W-1:0]  br_target, im_addr, id_pc;
    logic [INSTR_W-1:0] im_instr, id_instr;
    logic               w_rst, w_br_taken, w_id_ready, w_im_rd_en, w_id_valid, w_halted;
    logic [ADDR_W-1:0]  w_br_target, w_im_addr, w_id_pc;
    logic [INSTR_W-1:0] w_im_instr, w_id_instr;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt, perf_stall_cnt, w_perf_fetch_cnt, w_perf_stall_cnt;
`endif

    logic [INSTR_W-1:0] mem [2048];

    fetch_unit #(.QDEPTH(QD), .RESET_PC(11'h000)) u_dut (
        .clk(clk), .rst(rst), .im_addr(im_addr), .im_rd_en(im_rd_en), .im_instr(im_instr),
        .br_taken(br_taken), .br_target(br_target), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .halted(halted)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    fetch_unit #(.QDEPTH(QD), .RESET_PC(11'h7FE)) u_wrap (
        .clk(clk), .rst(w_rst), .im_addr(w_im_addr), .im_rd_en(w_im_rd_en), .im_instr(w_im_instr),
        .br_taken(w_br_taken), .br_target(w_br_target), .id_valid(w_id_valid), .id_ready(w_id_ready),
        .id_instr(w_id_instr), .id_pc(w_id_pc), .halted(w_halted)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(w_perf_fetch_cnt), .perf_stall_cnt(w_perf_stall_cnt)
`endif
    );

    // Instruction memory: samples the read enable on the negedge.
    initial begin
        im_instr   = '0;
        w_im_instr = '0;
    end
    always @(negedge clk) begin
        if (im_rd_en)   im_instr   = mem[im_addr];
        if (w_im_rd_en) w_im_instr = mem[w_im_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        br;
        logic [10:0] tgt;
        logic        vld;
        logic [10:0] pc;
        logic        rd_en;
        logic [10:0] addr;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic br, input logic [10:0] tgt,
                                input logic vld, input logic [10:0] pc,
                                input logic rd_en, input logic [10:0] addr);
        vec_t v;
        v.rdy = rdy; v.br = br; v.tgt = tgt; v.vld = vld; v.pc = pc; v.rd_en = rd_en; v.addr = addr;
        return v;
    endfunction

    // Reference model state: a plain queue of {instr, pc} plus PC, halt and hold-value.
    fetch_entry_t m_q[$];
    logic [10:0]  m_pc;
    logic         m_halt;
    fetch_entry_t m_last;
    int           m_fc, m_sc;

    task automatic model_edge(input logic r, input logic rdy, input logic br, input logic [10:0] tgt);
        logic [15:0] w;
        logic        go;
        if (r) begin
            m_q.delete();
            m_pc = 11'h000; m_halt = 1'b0; m_last = '0; m_fc = 0; m_sc = 0;
        end else begin
            if (m_q.size() != 0) m_last = m_q[0];
            if (!m_halt && !br && m_q.size() == QD && m_sc < 65535) m_sc++;
            if (br) begin
                m_q.delete();
                m_pc   = tgt;
                m_halt = 1'b0;
            end else begin
                go = !m_halt && (m_q.size() < QD);
                if (rdy && m_q.size() != 0) void'(m_q.pop_front());
                if (go) begin
                    w = mem[m_pc];
                    m_q.push_back('{instr: w, pc: m_pc});
                    if (w[15:12] == 4'hF) m_halt = 1'b1;
                    m_pc = (m_pc == 11'h7FF) ? 11'h000 : m_pc + 11'd1;
                    if (m_fc < 65535) m_fc++;
                end
            end
        end
    endtask

    vec_t        tv[14];
    logic [10:0] got[$];
    int          nreads;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h1000 + 16'(i);
        rst = 1'b1; id_ready = 1'b0; br_taken = 1'b0; br_target = '0;
        w_rst = 1'b1; w_id_ready = 1'b1; w_br_taken = 1'b0; w_br_target = '0;

        tv[0]  = mk(0, 0, 0,     0, 11'h000, 1, 11'h000);
        tv[1]  = mk(0, 0, 0,     1, 11'h000, 1, 11'h001);
        tv[2]  = mk(0, 0, 0,     1, 11'h000, 0, 11'h002);
        tv[3]  = mk(0, 0, 0,     1, 11'h000, 0, 11'h002);
        tv[4]  = mk(0, 0, 0,     1, 11'h000, 0, 11'h002);
        tv[5]  = mk(1, 0, 0,     1, 11'h000, 0, 11'h002);
        tv[6]  = mk(1, 0, 0,     1, 11'h001, 1, 11'h002);
        tv[7]  = mk(1, 0, 0,     1, 11'h002, 1, 11'h003);
        tv[8]  = mk(0, 0, 0,     1, 11'h003, 1, 11'h004);
        tv[9]  = mk(1, 0, 0,     1, 11'h003, 0, 11'h005);
        tv[10] = mk(0, 0, 0,     1, 11'h004, 1, 11'h005);
        tv[11] = mk(0, 1, 11'h040, 1, 11'h004, 0, 11'h006);
        tv[12] = mk(0, 0, 0,     0, 11'h004, 1, 11'h040);
        tv[13] = mk(1, 0, 0,     1, 11'h040, 1, 11'h041);

        // Reset state
        @(posedge clk); #7;
        check("rst_valid", id_valid, 0);
        check("rst_rd_en", im_rd_en, 0);
        check("rst_addr", im_addr, 11'h000);
        check("rst_halted", halted, 0);
        check("rst_instr", id_instr, 16'h0000);
        check("rst_pc", id_pc, 11'h000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Streaming, backpressure and redirect vectors
        for (int i = 0; i < 14; i++) begin
            id_ready = tv[i].rdy; br_taken = tv[i].br; br_target = tv[i].tgt;
            #6;
            check($sformatf("vec%0d_valid", i), id_valid, tv[i].vld);
            check($sformatf("vec%0d_rd_en", i), im_rd_en, tv[i].rd_en);
            check($sformatf("vec%0d_addr", i), im_addr, tv[i].addr);
            check($sformatf("vec%0d_pc", i), id_pc, tv[i].pc);
            if (tv[i].vld) check($sformatf("vec%0d_instr", i), id_instr, 16'h1000 + 16'(tv[i].pc));
            @(posedge clk); #1;
        end
        br_taken = 1'b0;

        // Halt on HLT at address 5, then release with a redirect
        mem[5] = 16'hF000;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; id_ready = 1'b1;
        got.delete(); nreads = 0;
        for (int c = 0; c < 20; c++) begin
            #6;
            if (im_rd_en) nreads++;
            if (id_valid) begin
                got.push_back(id_pc);
                check("halt_instr", id_instr, mem[id_pc]);
            end
            @(posedge clk); #1;
        end
        check("halt_reads", nreads, 6);
        check("halt_count", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++) check("halt_pc_order", got[i], i);
        #6;
        check("halt_flag", halted, 1);
        check("halt_rd_en", im_rd_en, 0);
        check("halt_addr", im_addr, 11'h006);
        @(posedge clk); #1;
        br_taken = 1'b1; br_target = 11'h010;
        @(posedge clk); #1;
        br_taken = 1'b0;
        #6;
        check("resume_halted", halted, 0);
        check("resume_addr", im_addr, 11'h010);
        check("resume_rd_en", im_rd_en, 1);
        check("resume_valid", id_valid, 0);
        @(posedge clk); #7;
        check("resume_head_valid", id_valid, 1);
        check("resume_head_pc", id_pc, 11'h010);
        check("resume_head_instr", id_instr, 16'h1010);
        mem[5] = 16'h1005;
        @(posedge clk); #1;

        // Reset mid-run with two entries queued
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; id_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #6;
        check("midrst_pre_valid", id_valid, 1);
        check("midrst_pre_addr", im_addr, 11'h002);
        @(posedge clk); #1;
        rst = 1'b1;
        #6;
        check("midrst_during_valid", id_valid, 0);
        check("midrst_during_rd_en", im_rd_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #6;
        check("midrst_valid", id_valid, 0);
        check("midrst_addr", im_addr, 11'h000);
`ifdef FETCH_PERF_EN
        check("midrst_perf_fetch", perf_fetch_cnt, 0);
        check("midrst_perf_stall", perf_stall_cnt, 0);
`endif
        @(posedge clk); #1;

        // PC wrap on the instance reset to 0x7FE
        @(posedge clk); #1;
        w_rst = 1'b0;
        got.delete();
        for (int c = 0; c < 6; c++) begin
            #6;
            if (w_id_valid) begin
                got.push_back(w_id_pc);
                check("wrap_instr", w_id_instr, mem[w_id_pc]);
            end
            @(posedge clk); #1;
        end
        check("wrap_count", got.size(), 5);
        if (got.size() >= 4) begin
            check("wrap_pc0", got[0], 11'h7FE);
            check("wrap_pc1", got[1], 11'h7FF);
            check("wrap_pc2", got[2], 11'h000);
            check("wrap_pc3", got[3], 11'h001);
        end
        w_rst = 1'b1;

        // Random traffic against the reference model
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        rst = 1'b1; id_ready = 1'b0; br_taken = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 1'b0, '0);
        #1;
        for (int c = 0; c < 3000; c++) begin
            logic prev_br;
            prev_br   = br_taken;
            rst       = ($urandom_range(0, 99) == 0);
            id_ready  = ($urandom_range(0, 9) < 7);
            br_taken  = !prev_br && ($urandom_range(0, 11) == 0);
            br_target = 11'($urandom);
            #6;
            check("rnd_addr", im_addr, m_pc);
            check("rnd_rd_en", im_rd_en, !rst && !m_halt && !br_taken && (m_q.size() < QD));
            check("rnd_valid", id_valid, !rst && (m_q.size() != 0));
            check("rnd_halted", halted, m_halt);
            check("rnd_pc", id_pc, (m_q.size() != 0) ? m_q[0].pc : m_last.pc);
            check("rnd_instr", id_instr, (m_q.size() != 0) ? m_q[0].instr : m_last.instr);
`ifdef FETCH_PERF_EN
            check("rnd_perf_fetch", perf_fetch_cnt, m_fc);
            check("rnd_perf_stall", perf_stall_cnt, m_sc);
`endif
            @(posedge clk);
            model_edge(rst, id_ready, br_taken, br_target);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 2K x 16 instruction memory (IM).
- Owns the PC, drives IM address/read-enable, and captures each returned word into a small instruction queue.
- Presents instructions to decode with a valid/ready handshake.
- Handles branch redirect/flush and halts fetching on the HLT opcode.

Parameters:
- ADDR_W, 11, PC / IM address width (2048 words).
- INSTR_W, 16, instruction width.
- QDEPTH, 2, instruction queue entries (power of 2, >=2).
- RESET_PC, 11'h000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- im_addr  out  ADDR_W  IM read address; equals the PC register.
- im_rd_en  out  1  IM read enable; the IM samples it on negedge.
- im_instr  in  INSTR_W  IM read data; valid before the posedge following an enabled negedge read.
- br_taken  in  1  redirect request from execute; single-cycle pulse.
- br_target  in  ADDR_W  redirect destination.
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  INSTR_W  head instruction.
- id_pc  out  ADDR_W  address of the head instruction.
- halted  out  1  fetch stopped on HLT.

Behaviour:
- Reset: one clock, synchronous, active-high, as fixed above.
  - At each posedge with rst=1: pc<=RESET_PC; queue emptied (count=0, pointers 0); halted<=0.
  - id_valid=0 and im_rd_en=0 while rst=1.
  - Reset mid-operation discards all queued entries.
- Fetch enable (combinational): fetch_go = !rst && !halted && !br_taken && (count < QDEPTH).
  - im_rd_en = fetch_go.
  - im_addr = pc at all times.
  - No dependence on id_ready.
- Fetch timing:
  - At posedge ending cycle N, if fetch_go(N): push {im_instr, pc} and pc <= pc+1.
  - This gives 1-cycle IM latency absorbed within the cycle: the IM reads on the mid-cycle negedge.
- PC arithmetic:
  - Modulo 2^ADDR_W; 0x7FF+1 wraps to 0x000.
  - No carry-out or flag.
- Pop: on posedge with id_valid && id_ready, the head is removed.
  - Simultaneous push and pop are both honoured; count is unchanged.
- Full: count==QDEPTH -> fetch_go=0; pc holds; the IM output is stale and must never be pushed.
- Empty: id_valid=0; id_instr/id_pc are don't-care but must hold their last value (no X after reset: reset to 0).
- Redirect, when br_taken=1 at a posedge:
  - Flush queue (count<=0).
  - pc <= br_target.
  - halted <= 0.
  - No push that cycle; any pop that cycle is ignored.
  - br_taken has priority over push, pop and halt.
  - The first redirected instruction appears at id_valid 2 cycles after the br_taken edge: 1 cycle fetch, then queue head.
- Halt:
  - When a pushed word has opcode im_instr[15:12]==OPC_HLT (4'hF), halted <= 1 at the same edge.
  - The HLT itself is enqueued and delivered.
  - Fetch stays stopped until br_taken or rst.
  - pc has already advanced past the HLT.
- id_valid = (count != 0).
- id_instr and id_pc come from the queue head storage (registered; no combinational path from im_instr).

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds output ports:
  - perf_fetch_cnt [15:0]: increments on every push.
  - perf_stall_cnt [15:0]: increments on cycles with !halted && !br_taken && count==QDEPTH.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - ADDR_W and INSTR_W localparams.
  - OPC_HLT = 4'hF.
  - typedef struct packed fetch_entry_t {instr[15:0], pc[10:0]}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, depth QDEPTH.
  - Inputs: push, pop, flush.
  - Outputs: head, count, full, empty.
  - flush has priority over push/pop.
- The top holds the PC, halt flag, fetch_go logic and perf counters.

Test Plan:
- Streaming:
  - Stimulus: IM preloaded mem[i]=16'h1000+i; rst 2 cycles; id_ready=1.
  - Response: im_addr 0,1,2,... one per cycle; first id_valid with id_instr=16'h1000, id_pc=0 one cycle after first im_rd_en; then one instruction per cycle, no gaps.
- Backpressure:
  - Stimulus: id_ready=0 for 5 cycles after reset.
  - Response: queue holds pc 0,1; im_rd_en=0 and im_addr=2 held. After id_ready=1: delivered pcs 0,1,2,3 in order, no loss or duplicate.
- Redirect:
  - Stimulus: full queue (pcs 4,5); br_taken=1, br_target=11'h040.
  - Response: next cycle id_valid=0 and im_addr=0x040; following cycle id_pc=0x040, id_instr=mem[0x40].
- Halt:
  - Stimulus: mem[5]=16'hF000.
  - Response: pcs 0..5 delivered; halted=1; im_rd_en=0 indefinitely. Then br_taken to 0x010: halted=0 and fetch resumes at 0x010.
- Wrap:
  - Stimulus: RESET_PC=11'h7FE.
  - Response: fetched/delivered pcs 0x7FE, 0x7FF, 0x000, 0x001.
- Reset mid-run:
  - Stimulus: rst asserted with 2 entries queued and id_ready=0.
  - Response: next cycle id_valid=0, im_addr=RESET_PC; perf counters (if FETCH_PERF_EN) read 0.
